// File: rtl/mdu_hilo_ctrl.sv
// HI/LO owner and sequencer for the multiply/divide path: accepts HI/LO-class ops,
// launches one Mult or Div operation at a time and retires its result into HI/LO.
module mdu_hilo_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        stall,
  output logic [31:0] mf_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero,
  output logic        timeout_err,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  output logic        mul_valid_in,
  output logic        mul_sign,
  input  logic        mul_valid_out,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  output logic        div_valid_in,
  output logic        div_sign,
  input  logic        div_valid_out,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_e;
  typedef enum logic [2:0] {
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO
  } op_e;

  localparam int unsigned   CW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q;
  op_e           op_kind;
  logic          accept, is_mul, is_div, div_zero;
  logic          launch_mul, launch_div, retire_mul, retire_div, expire;

  assign op_kind    = op_e'(op);
  assign stall      = op_valid && (state_q != IDLE);
  assign accept     = op_valid && !stall;
  assign is_mul     = (op_kind == OP_MULT) || (op_kind == OP_MULTU);
  assign is_div     = (op_kind == OP_DIV)  || (op_kind == OP_DIVU);
  assign div_zero   = (rt_val == '0);
  assign launch_mul = accept && is_mul;
  assign launch_div = accept && is_div && !div_zero;
  assign retire_mul = (state_q == MUL_WAIT) && mul_valid_out;
  assign retire_div = (state_q == DIV_WAIT) && div_valid_out;
  // A result arriving in the final wait cycle beats the timeout.
  assign expire     = (state_q != IDLE) && !retire_mul && !retire_div &&
                      (wait_cnt_q == LAST_WAIT);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (launch_mul)      state_d = MUL_WAIT;
        else if (launch_div) state_d = DIV_WAIT;
      end
      MUL_WAIT: if (retire_mul || expire) state_d = IDLE;
      DIV_WAIT: if (retire_div || expire) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    mf_data = '0;
    if (accept && op_kind == OP_MFHI)      mf_data = hi;
    else if (accept && op_kind == OP_MFLO) mf_data = lo;
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      // Held at zero while idle, so each wait state starts counting from zero.
      if (state_q == IDLE) wait_cnt_q <= '0;
      else                 wait_cnt_q <= wait_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi           <= '0;
      lo           <= '0;
      mdu_a        <= '0;
      mdu_b        <= '0;
      mul_valid_in <= 1'b0;
      mul_sign     <= 1'b0;
      div_valid_in <= 1'b0;
      div_sign     <= 1'b0;
      div_by_zero  <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      mul_valid_in <= launch_mul;
      div_valid_in <= launch_div;
      div_by_zero  <= accept && is_div && div_zero;
      timeout_err  <= expire;

      // Operands and sign only change on launch, so they stay stable for the whole wait.
      if (launch_mul || launch_div) begin
        mdu_a <= rs_val;
        mdu_b <= rt_val;
      end
      if (launch_mul) mul_sign <= (op_kind == OP_MULT);
      if (launch_div) div_sign <= (op_kind == OP_DIV);

      if (retire_mul) begin
        hi <= mul_hi;
        lo <= mul_lo;
      end else if (retire_div) begin
        hi <= div_hi;
        lo <= div_lo;
      end else if (accept && op_kind == OP_MTHI) begin
        hi <= rs_val;
      end else if (accept && op_kind == OP_MTLO) begin
        lo <= rs_val;
      end
    end
  end

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Self-checking bench for mdu_hilo_ctrl: directed table, hand-written corner sequences,
// then randomized traffic against a transaction-level HI/LO reference model.
`timescale 1ns/1ps
module tb_mdu_hilo_ctrl;

  localparam int TO = 8;
  localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2, OP_DIVU = 3'd3,
                         OP_MTHI = 3'd4, OP_MTLO  = 3'd5, OP_MFHI = 3'd6, OP_MFLO = 3'd7;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        stall;
  logic [31:0] mf_data, hi, lo, mdu_a, mdu_b;
  logic        div_by_zero, timeout_err;
  logic        mul_valid_in, mul_sign, mul_valid_out;
  logic [31:0] mul_hi, mul_lo;
  logic        div_valid_in, div_sign, div_valid_out;
  logic [31:0] div_hi, div_lo;

  always #5 clk = ~clk;

  mdu_hilo_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .mf_data(mf_data),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero), .timeout_err(timeout_err),
    .mdu_a(mdu_a), .mdu_b(mdu_b),
    .mul_valid_in(mul_valid_in), .mul_sign(mul_sign), .mul_valid_out(mul_valid_out),
    .mul_hi(mul_hi), .mul_lo(mul_lo),
    .div_valid_in(div_valid_in), .div_sign(div_sign), .div_valid_out(div_valid_out),
    .div_hi(div_hi), .div_lo(div_lo)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Arithmetic result of a unit: mult -> {hi,lo} product, div -> {remainder, quotient}.
  function automatic logic [63:0] unit_result(input bit is_div, input bit sgn,
                                              input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (!is_div)      r = 64'(sa * sb);
    else if (sb == 0) r = '0;
    else              r = {32'(sa % sb), 32'(sa / sb)};
    return r;
  endfunction

  // ---------------- reference model state ----------------
  typedef enum {P_NONE, P_MUL, P_DIV} pend_e;
  pend_e       pend = P_NONE;
  logic [31:0] m_hi, m_lo, m_a, m_b;
  bit          m_sgn;
  int          waited;
  bit          exp_mvin, exp_dvin, exp_dbz, exp_to;

  // ---------------- Mult/Div unit behavioural models ----------------
  int          mul_lat = 4, div_lat = 4;
  bit          div_mute = 0, rand_lat = 0, spurious_en = 0, inj_div = 0;
  int          mul_cnt, div_cnt;
  logic [63:0] mul_res, div_res;

  initial begin
    mul_valid_out = 1'b0; div_valid_out = 1'b0;
    mul_hi = '0; mul_lo = '0; div_hi = '0; div_lo = '0;
    mul_cnt = 0; div_cnt = 0; mul_res = '0; div_res = '0;
    forever begin
      @(negedge clk);
      mul_valid_out = 1'b0;
      div_valid_out = 1'b0;
      if (mul_valid_in) begin
        mul_cnt = rand_lat ? int'($urandom_range(1, 10)) : mul_lat;
        mul_res = unit_result(1'b0, mul_sign, mdu_a, mdu_b);
      end else if (mul_cnt > 0) begin
        mul_cnt--;
        if (mul_cnt == 0) begin
          mul_valid_out = 1'b1;
          mul_hi = mul_res[63:32];
          mul_lo = mul_res[31:0];
        end
      end
      if (div_valid_in) begin
        div_cnt = div_mute ? 0 : (rand_lat ? int'($urandom_range(1, 10)) : div_lat);
        div_res = unit_result(1'b1, div_sign, mdu_a, mdu_b);
      end else if (div_cnt > 0) begin
        div_cnt--;
        if (div_cnt == 0) begin
          div_valid_out = 1'b1;
          div_hi = div_res[63:32];
          div_lo = div_res[31:0];
        end
      end
      if (inj_div) begin
        div_valid_out = 1'b1;
        div_hi = 32'h5555_5555;
        div_lo = 32'hAAAA_AAAA;
      end
      // Stray results from a unit nobody is waiting on.
      if (spurious_en && !mul_valid_out && pend != P_MUL && $urandom_range(0, 15) == 0) begin
        mul_valid_out = 1'b1; mul_hi = $urandom; mul_lo = $urandom;
      end
      if (spurious_en && !div_valid_out && pend != P_DIV && $urandom_range(0, 15) == 0) begin
        div_valid_out = 1'b1; div_hi = $urandom; div_lo = $urandom;
      end
    end
  end

  task automatic drive(input bit v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = v; op = o; rs_val = a; rt_val = b;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Compare DUT outputs for the current cycle with the model's predictions.
  task automatic model_check(input bit v, input logic [2:0] o);
    logic [31:0] emf;
    emf = '0;
    if (v && pend == P_NONE && o == OP_MFHI) emf = m_hi;
    if (v && pend == P_NONE && o == OP_MFLO) emf = m_lo;
    check("rnd stall", stall, 32'(v && pend != P_NONE));
    check("rnd mf_data", mf_data, emf);
    check("rnd hi", hi, m_hi);
    check("rnd lo", lo, m_lo);
    check("rnd mul_valid_in", mul_valid_in, 32'(exp_mvin));
    check("rnd div_valid_in", div_valid_in, 32'(exp_dvin));
    check("rnd div_by_zero", div_by_zero, 32'(exp_dbz));
    check("rnd timeout_err", timeout_err, 32'(exp_to));
    if (exp_mvin || exp_dvin) begin
      check("rnd mdu_a", mdu_a, m_a);
      check("rnd mdu_b", mdu_b, m_b);
      check("rnd sign", exp_mvin ? mul_sign : div_sign, 32'(m_sgn));
    end
  endtask

  // Advance the model across one clock edge given the inputs and unit responses.
  task automatic model_step(input bit v, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input bit mvo, input bit dvo);
    exp_mvin = 0; exp_dvin = 0; exp_dbz = 0; exp_to = 0;
    if (pend == P_NONE) begin
      if (v) begin
        case (o)
          OP_MULT, OP_MULTU: begin
            pend = P_MUL; m_a = a; m_b = b; m_sgn = (o == OP_MULT); waited = 0; exp_mvin = 1;
          end
          OP_DIV, OP_DIVU: begin
            if (b == 0) exp_dbz = 1;
            else begin
              pend = P_DIV; m_a = a; m_b = b; m_sgn = (o == OP_DIV); waited = 0; exp_dvin = 1;
            end
          end
          OP_MTHI: m_hi = a;
          OP_MTLO: m_lo = a;
          default: ;
        endcase
      end
    end else begin
      waited++;
      if ((pend == P_MUL && mvo) || (pend == P_DIV && dvo)) begin
        {m_hi, m_lo} = unit_result(pend == P_DIV, m_sgn, m_a, m_b);
        pend = P_NONE;
      end else if (waited == TO) begin
        pend = P_NONE;
        exp_to = 1;
      end
    end
  endtask

  task automatic rand_cycle(input bit v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bit mvo, dvo;
    drive(v, o, a, b);
    #3;
    model_check(v, o);
    @(negedge clk); #1;
    mvo = mul_valid_out;
    dvo = div_valid_out;
    model_step(v, o, a, b, mvo, dvo);
    next_cycle();
  endtask

  typedef struct {
    bit          v;
    logic [2:0]  op;
    logic [31:0] a, b;
    bit          e_stall;
    logic [31:0] e_mf;
    bit          e_dbz;
    logic [31:0] e_hi, e_lo;
  } vec_t;
  vec_t tbl[10];

  initial begin
    bit          v;
    logic [2:0]  o;
    logic [31:0] a, b;
    int          pulses, stall_cycles, launch_c, to_c;
    bit          got_idle;

    tbl[0] = '{1'b1, OP_MTHI, 32'h0000_1234, 32'h0, 1'b0, 32'h0,         1'b0, 32'h0,    32'h0};
    tbl[1] = '{1'b1, OP_MFHI, 32'h0,         32'h0, 1'b0, 32'h0000_1234, 1'b0, 32'h1234, 32'h0};
    tbl[2] = '{1'b1, OP_MTLO, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0,         1'b0, 32'h1234, 32'h0};
    tbl[3] = '{1'b1, OP_MFLO, 32'h0,         32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h1234, 32'hDEAD_BEEF};
    tbl[4] = '{1'b0, OP_MFHI, 32'h0,         32'h0, 1'b0, 32'h0,         1'b0, 32'h1234, 32'hDEAD_BEEF};
    tbl[5] = '{1'b1, OP_DIVU, 32'h7,         32'h0, 1'b0, 32'h0,         1'b0, 32'h1234, 32'hDEAD_BEEF};
    tbl[6] = '{1'b1, OP_MFHI, 32'h0,         32'h0, 1'b0, 32'h0000_1234, 1'b1, 32'h1234, 32'hDEAD_BEEF};
    tbl[7] = '{1'b1, OP_DIV,  32'hFFFF_FFFB, 32'h0, 1'b0, 32'h0,         1'b0, 32'h1234, 32'hDEAD_BEEF};
    tbl[8] = '{1'b0, OP_MTHI, 32'h0000_FFFF, 32'h0, 1'b0, 32'h0,         1'b1, 32'h1234, 32'hDEAD_BEEF};
    tbl[9] = '{1'b1, OP_MFLO, 32'h0,         32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h1234, 32'hDEAD_BEEF};

    // Reset state
    reset_n = 1'b0;
    drive(1'b0, OP_MULT, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    drive(1'b1, OP_MFHI, 32'h0, 32'h0);
    #3;
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset stall", stall, 32'h0);
    check("reset mdu_a", mdu_a, 32'h0);
    check("reset mdu_b", mdu_b, 32'h0);
    check("reset pulses", {27'h0, mul_valid_in, div_valid_in, div_by_zero, timeout_err, mul_sign | div_sign}, 32'h0);
    drive(1'b0, OP_MFHI, 32'h0, 32'h0);
    next_cycle();

    // Table of single-cycle ops
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].a, tbl[i].b);
      #3;
      check($sformatf("tbl[%0d] stall", i), stall, 32'(tbl[i].e_stall));
      check($sformatf("tbl[%0d] mf_data", i), mf_data, tbl[i].e_mf);
      check($sformatf("tbl[%0d] div_by_zero", i), div_by_zero, 32'(tbl[i].e_dbz));
      check($sformatf("tbl[%0d] hi", i), hi, tbl[i].e_hi);
      check($sformatf("tbl[%0d] lo", i), lo, tbl[i].e_lo);
      check($sformatf("tbl[%0d] launches", i), {30'h0, mul_valid_in, div_valid_in}, 32'h0);
      next_cycle();
    end

    // MULT -3*5, Mult latency 4, MFLO held behind it
    drive(1'b1, OP_MULT, 32'hFFFF_FFFD, 32'h5);
    #3 check("mult accept stall", stall, 32'h0);
    next_cycle();
    drive(1'b1, OP_MFLO, 32'h0, 32'h0);
    pulses = 0; stall_cycles = 0; got_idle = 0;
    for (int c = 0; c < 20; c++) begin
      #3;
      if (mul_valid_in) begin
        pulses++;
        check("mult sign", mul_sign, 32'h1);
        check("mult mdu_a", mdu_a, 32'hFFFF_FFFD);
        check("mult mdu_b", mdu_b, 32'h5);
      end
      if (!stall) begin
        got_idle = 1;
        check("mult mflo", mf_data, 32'hFFFF_FFF1);
        check("mult hi", hi, 32'hFFFF_FFFF);
        check("mult lo", lo, 32'hFFFF_FFF1);
        break;
      end
      stall_cycles++;
      next_cycle();
    end
    check("mult launch pulses", pulses, 32'd1);
    check("mult stall cycles", stall_cycles, 32'd5);
    check("mult stall released", 32'(got_idle), 32'h1);
    next_cycle();

    // DIVU by zero, then MFHI
    drive(1'b1, OP_DIVU, 32'h7, 32'h0);
    #3 check("divz stall", stall, 32'h0);
    next_cycle();
    drive(1'b1, OP_MFHI, 32'h0, 32'h0);
    #3;
    check("divz pulse", div_by_zero, 32'h1);
    check("divz no launch", div_valid_in, 32'h0);
    check("divz mfhi stall", stall, 32'h0);
    check("divz mfhi data", mf_data, 32'hFFFF_FFFF);
    next_cycle();
    drive(1'b0, OP_MFHI, 32'h0, 32'h0);
    #3;
    check("divz pulse end", div_by_zero, 32'h0);
    check("divz no launch 2", div_valid_in, 32'h0);
    check("divz hi", hi, 32'hFFFF_FFFF);
    check("divz lo", lo, 32'hFFFF_FFF1);
    next_cycle();

    // DIV -7/2 with a Div that never answers
    div_mute = 1;
    drive(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'h2);
    next_cycle();
    drive(1'b1, OP_MFHI, 32'h0, 32'h0);
    launch_c = -1; to_c = -1;
    for (int c = 1; c < 30; c++) begin
      #3;
      if (div_valid_in) begin
        launch_c = c;
        check("tmo div_sign", div_sign, 32'h1);
        check("tmo mdu_a", mdu_a, 32'hFFFF_FFF9);
      end
      if (timeout_err) begin
        to_c = c;
        check("tmo idle stall", stall, 32'h0);
        check("tmo mfhi", mf_data, 32'hFFFF_FFFF);
        break;
      end
      next_cycle();
    end
    check("tmo launch cycle", launch_c, 32'd1);
    check("tmo wait cycles", to_c - launch_c, 32'd8);
    next_cycle();
    drive(1'b0, OP_MFHI, 32'h0, 32'h0);
    #3 check("tmo pulse end", timeout_err, 32'h0);
    next_cycle();
    inj_div = 1;
    next_cycle();
    inj_div = 0;
    next_cycle();
    #3;
    check("tmo late hi", hi, 32'hFFFF_FFFF);
    check("tmo late lo", lo, 32'hFFFF_FFF1);
    check("tmo late stall", stall, 32'h0);
    div_mute = 0;
    next_cycle();

    // Reset in the middle of a MUL_WAIT, with the result landing afterwards
    drive(1'b1, OP_MULT, 32'h3, 32'h4);
    next_cycle();
    drive(1'b0, OP_MFLO, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    #1 reset_n = 1'b0;
    drive(1'b1, OP_MFLO, 32'h0, 32'h0);
    #1;
    check("rst mid stall", stall, 32'h0);
    check("rst mid hi", hi, 32'h0);
    check("rst mid lo", lo, 32'h0);
    @(posedge clk); #2 reset_n = 1'b1;
    next_cycle();
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      #3;
      check("rst late hi", hi, 32'h0);
      check("rst late lo", lo, 32'h0);
      check("rst late stall", stall, 32'h0);
      check("rst late mflo", mf_data, 32'h0);
      next_cycle();
    end
    drive(1'b0, OP_MFLO, 32'h0, 32'h0);
    repeat (12) next_cycle();

    // Randomized traffic against the reference model
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    m_hi = '0; m_lo = '0; m_a = '0; m_b = '0; m_sgn = 0; waited = 0;
    exp_mvin = 0; exp_dvin = 0; exp_dbz = 0; exp_to = 0;
    pend = P_NONE;
    rand_lat = 1; spurious_en = 1;
    v = 0; o = '0; a = '0; b = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!(v && pend != P_NONE)) begin
        v = ($urandom_range(0, 9) < 7);
        o = 3'($urandom_range(0, 7));
        a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
        b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      end
      rand_cycle(v, o, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
